// File: rtl/bp_perf_pkg.sv
// Shared types and constants for the branch-predictor measurement controller.
// Package bp_perf_pkg: FSM states, readout word indices and default marker encodings.
package bp_perf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    COUNT,
    DRAIN,
    READOUT
  } perf_state_e;

  localparam logic [1:0] IDX_INSTR  = 2'd0;
  localparam logic [1:0] IDX_BR     = 2'd1;
  localparam logic [1:0] IDX_MISS   = 2'd2;
  localparam logic [1:0] IDX_STATUS = 2'd3;

  // ori x0,x0,0 opens the measured window, andi x0,x0,0 closes it
  localparam logic [31:0] START_MARK_DEF = 32'h0000_6013;
  localparam logic [31:0] STOP_MARK_DEF  = 32'h0000_7013;

  function automatic logic [1:0] status_bits(input logic ovf, input logic win_hit);
    return {win_hit, ovf};
  endfunction

endpackage

// File: rtl/bp_perf_ctrl_if.sv
// Readout stream of the perf controller: one word per valid/ready beat, tagged with its index.
interface bp_perf_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             rd_valid;
  logic             rd_ready;
  logic [CNT_W-1:0] rd_data;
  logic [1:0]       rd_idx;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_idx,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_idx,
    output rd_ready
  );
endinterface

// File: rtl/bp_sat_counter.sv
// Saturating event counter with synchronous clear; sat_hit_o flags an increment lost at all-ones.
module bp_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] value_o,
  output logic             sat_hit_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;

  assign at_max    = &cnt_q;
  assign sat_hit_o = inc_i && at_max && !clr_i;
  assign value_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bp_perf_ctrl.sv
// Branch-predictor measurement controller: arm, count between marker instructions, drain, stream results.
// Optional feature macro PERF_WINDOW_EN: ends the window after WINDOW counted instructions.
module bp_perf_ctrl
  import bp_perf_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter logic [31:0] START_MARK = START_MARK_DEF,
  parameter logic [31:0] STOP_MARK  = STOP_MARK_DEF,
  parameter int unsigned DRAIN_CYC  = 2,
  parameter int unsigned WINDOW     = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  instr_i,
  input  logic         instr_vld_i,
  input  logic         br_instr_i,
  input  logic         br_miss_i,
  input  logic         arm_i,
  input  logic         abort_i,
  bp_perf_ctrl_if.master rd,
  output logic         busy_o,
  output logic         ovf_o
);

`ifdef PERF_WINDOW_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  // DRAIN_CYC is expected to be at least 1; the drain counter holds DRAIN_CYC-1 down to 0
  localparam int unsigned DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  // A window the counter can never represent is simply never reached
  localparam bit WIN_FITS = (WINDOW != 0) && ((CNT_W >= 32) || (WINDOW < (32'd1 << CNT_W)));
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  perf_state_e      state_q;
  logic [DRN_W-1:0] drain_q;
  logic             rd_valid_q;
  logic [1:0]       rd_idx_q;
  logic [CNT_W-1:0] rd_data_q;
  logic             ovf_q;
  logic             win_hit_q;

  logic [CNT_W-1:0] instr_cnt, br_cnt, miss_cnt;
  logic             instr_sat, br_sat, miss_sat;
  logic             is_start, is_stop;
  logic             cnt_clr, instr_inc, br_inc, miss_inc;
  logic             win_reach, rd_fire;
  logic [1:0]       next_idx;
  logic [CNT_W-1:0] next_word;

  assign is_start = instr_vld_i && (instr_i == START_MARK);
  assign is_stop  = instr_vld_i && (instr_i == STOP_MARK);

  // Branch events keep counting through DRAIN because they resolve a few stages after fetch
  assign cnt_clr   = (state_q == IDLE) && arm_i && !abort_i;
  assign instr_inc = (state_q == COUNT) && instr_vld_i && !is_stop && !abort_i;
  assign br_inc    = ((state_q == COUNT) || (state_q == DRAIN)) && br_instr_i && !abort_i;
  assign miss_inc  = br_inc && br_miss_i;
  assign win_reach = WIN_EN && WIN_FITS && instr_inc && (instr_cnt == WIN_LAST);
  assign rd_fire   = rd_valid_q && rd.rd_ready;
  assign next_idx  = rd_idx_q + 2'd1;

  bp_sat_counter #(.CNT_W(CNT_W)) uInstrCnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr), .inc_i(instr_inc),
    .value_o(instr_cnt), .sat_hit_o(instr_sat)
  );

  bp_sat_counter #(.CNT_W(CNT_W)) uBrCnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr), .inc_i(br_inc),
    .value_o(br_cnt), .sat_hit_o(br_sat)
  );

  bp_sat_counter #(.CNT_W(CNT_W)) uMissCnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr), .inc_i(miss_inc),
    .value_o(miss_cnt), .sat_hit_o(miss_sat)
  );

  always_comb begin
    next_word = '0;
    case (next_idx)
      IDX_BR:     next_word = br_cnt;
      IDX_MISS:   next_word = miss_cnt;
      IDX_STATUS: next_word[1:0] = status_bits(ovf_q, win_hit_q);
      default:    next_word = instr_cnt;
    endcase
  end

  // Readout words are loaded one beat ahead so rd_data stays put while the consumer stalls
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      drain_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= IDX_INSTR;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
      win_hit_q  <= 1'b0;
    end else if (abort_i) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= IDX_INSTR;
    end else begin
      if (instr_sat || br_sat || miss_sat) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (arm_i) begin
            state_q   <= ARMED;
            ovf_q     <= 1'b0;
            win_hit_q <= 1'b0;
          end
        end
        ARMED: begin
          if (is_start) begin
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (is_stop || win_reach) begin
            state_q <= DRAIN;
            drain_q <= DRN_W'(DRAIN_CYC - 1);
            if (win_reach) begin
              win_hit_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q    <= READOUT;
            rd_valid_q <= 1'b1;
            rd_idx_q   <= IDX_INSTR;
            rd_data_q  <= instr_cnt;
          end else begin
            drain_q <= drain_q - DRN_W'(1);
          end
        end
        READOUT: begin
          if (rd_fire) begin
            if (rd_idx_q == IDX_STATUS) begin
              state_q    <= IDLE;
              rd_valid_q <= 1'b0;
              rd_idx_q   <= IDX_INSTR;
            end else begin
              rd_idx_q  <= next_idx;
              rd_data_q <= next_word;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_data_q;
  assign rd.rd_idx   = rd_idx_q;
  assign busy_o      = (state_q != IDLE);
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_bp_perf_ctrl.sv
// Directed bench for bp_perf_ctrl: three instances (32-bit, 4-bit, WINDOW=8) share the event taps,
// only the armed instance reacts; expectations follow PERF_WINDOW_EN when it is defined.
module tb_bp_perf_ctrl;

  localparam logic [31:0] START = 32'h0000_6013;
  localparam logic [31:0] STOP  = 32'h0000_7013;
  localparam logic [31:0] ADDI  = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instrVld, brInstr, brMiss, abortP;
  logic        armMain, armSmall, armWin, readyDrv;
  logic        busyMain, busySmall, busyWin, ovfMain, ovfSmall, ovfWin;
  int          sel;
  int          assertCount = 0;
  int          failCount = 0;

  logic        curValid, curBusy;
  logic [31:0] curData;
  logic [1:0]  curIdx;

  always #5 clk = ~clk;

  bp_perf_ctrl_if #(.CNT_W(32)) ifMain ();
  bp_perf_ctrl_if #(.CNT_W(4))  ifSmall ();
  bp_perf_ctrl_if #(.CNT_W(32)) ifWin ();

  assign ifMain.rd_ready  = readyDrv && (sel == 0);
  assign ifSmall.rd_ready = readyDrv && (sel == 1);
  assign ifWin.rd_ready   = readyDrv && (sel == 2);

  bp_perf_ctrl #(.CNT_W(32)) dutMain (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_vld_i(instrVld),
    .br_instr_i(brInstr), .br_miss_i(brMiss), .arm_i(armMain), .abort_i(abortP),
    .rd(ifMain), .busy_o(busyMain), .ovf_o(ovfMain)
  );

  bp_perf_ctrl #(.CNT_W(4)) dutSmall (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_vld_i(instrVld),
    .br_instr_i(brInstr), .br_miss_i(brMiss), .arm_i(armSmall), .abort_i(abortP),
    .rd(ifSmall), .busy_o(busySmall), .ovf_o(ovfSmall)
  );

  bp_perf_ctrl #(.CNT_W(32), .WINDOW(8)) dutWin (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_vld_i(instrVld),
    .br_instr_i(brInstr), .br_miss_i(brMiss), .arm_i(armWin), .abort_i(abortP),
    .rd(ifWin), .busy_o(busyWin), .ovf_o(ovfWin)
  );

  always_comb begin
    curValid = ifMain.rd_valid;
    curData  = ifMain.rd_data;
    curIdx   = ifMain.rd_idx;
    curBusy  = busyMain;
    case (sel)
      1: begin
        curValid = ifSmall.rd_valid;
        curData  = 32'(ifSmall.rd_data);
        curIdx   = ifSmall.rd_idx;
        curBusy  = busySmall;
      end
      2: begin
        curValid = ifWin.rd_valid;
        curData  = ifWin.rd_data;
        curIdx   = ifWin.rd_idx;
        curBusy  = busyWin;
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] i, input logic v, input logic b, input logic m);
    instr    = i;
    instrVld = v;
    brInstr  = b;
    brMiss   = m;
    tick();
    instrVld = 1'b0;
    brInstr  = 1'b0;
    brMiss   = 1'b0;
  endtask

  task automatic pulseArm(input int which, input logic withAbort);
    armMain  = (which == 0);
    armSmall = (which == 1);
    armWin   = (which == 2);
    abortP   = withAbort;
    tick();
    armMain  = 1'b0;
    armSmall = 1'b0;
    armWin   = 1'b0;
    abortP   = 1'b0;
  endtask

  task automatic pulseAbort();
    abortP = 1'b1;
    tick();
    abortP = 1'b0;
  endtask

  task automatic readWords(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input int stallIdx, input int stallCycles);
    logic [31:0] exp [4];
    int n;
    exp = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (curValid !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      checkOutput($sformatf("%s_valid%0d", tag, i), 32'(curValid), 32'd1);
      checkOutput($sformatf("%s_idx%0d", tag, i), 32'(curIdx), 32'(i));
      checkOutput($sformatf("%s_data%0d", tag, i), curData, exp[i]);
      if (i == stallIdx) begin
        for (int s = 0; s < stallCycles; s++) begin
          tick();
          checkOutput($sformatf("%s_stallData%0d", tag, s), curData, exp[i]);
          checkOutput($sformatf("%s_stallIdx%0d", tag, s), 32'(curIdx), 32'(i));
        end
      end
      readyDrv = 1'b1;
      tick();
      readyDrv = 1'b0;
    end
    checkOutput({tag, "_validDone"}, 32'(curValid), 32'd0);
    checkOutput({tag, "_busyDone"}, 32'(curBusy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; instr = '0; instrVld = 0; brInstr = 0; brMiss = 0; abortP = 0;
    armMain = 0; armSmall = 0; armWin = 0; readyDrv = 0; sel = 0;
    repeat (3) tick();
    rst = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(curValid), 32'd0);
    checkOutput("rst_data", curData, 32'd0);
    checkOutput("rst_idx", 32'(curIdx), 32'd0);
    checkOutput("rst_busy", {29'd0, busyMain, busySmall, busyWin}, 32'd0);
    checkOutput("rst_ovf", {29'd0, ovfMain, ovfSmall, ovfWin}, 32'd0);

    $display("[TB] basic window: 10 instr, 4 br, 1 miss");
    pulseArm(0, 1'b0);
    checkOutput("arm_busy", 32'(busyMain), 32'd1);
    applyStimulus(ADDI, 1'b1, 1'b1, 1'b1);
    applyStimulus(START, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i == 5) ? START : ADDI, 1'b1, (i < 4), (i == 1));
    end
    applyStimulus(ADDI, 1'b0, 1'b0, 1'b1);
    applyStimulus(STOP, 1'b1, 1'b0, 1'b0);
    readWords("basic", 32'd10, 32'd4, 32'd1, 32'd0, -1, 0);
    checkOutput("basic_ovf", 32'(ovfMain), 32'd0);

    $display("[TB] branches in drain, stall on idx 1");
    pulseArm(0, 1'b0);
    applyStimulus(START, 1'b1, 1'b0, 1'b0);
    applyStimulus(ADDI, 1'b1, 1'b1, 1'b0);
    applyStimulus(ADDI, 1'b1, 1'b0, 1'b0);
    applyStimulus(ADDI, 1'b1, 1'b0, 1'b0);
    applyStimulus(STOP, 1'b1, 1'b0, 1'b0);
    applyStimulus(ADDI, 1'b1, 1'b1, 1'b1);
    applyStimulus(ADDI, 1'b0, 1'b1, 1'b0);
    applyStimulus(ADDI, 1'b1, 1'b1, 1'b1);
    readWords("drain", 32'd3, 32'd3, 32'd1, 32'd0, 1, 5);

    $display("[TB] reset mid-count");
    pulseArm(0, 1'b0);
    applyStimulus(START, 1'b1, 1'b0, 1'b0);
    applyStimulus(ADDI, 1'b1, 1'b1, 1'b0);
    applyStimulus(ADDI, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busyMain), 32'd0);
    checkOutput("midrst_instr", dutMain.uInstrCnt.value_o, 32'd0);
    checkOutput("midrst_br", dutMain.uBrCnt.value_o, 32'd0);

    $display("[TB] abort mid-count");
    pulseArm(0, 1'b0);
    applyStimulus(START, 1'b1, 1'b0, 1'b0);
    applyStimulus(ADDI, 1'b1, 1'b1, 1'b0);
    applyStimulus(ADDI, 1'b1, 1'b1, 1'b0);
    applyStimulus(ADDI, 1'b1, 1'b0, 1'b1);
    pulseArm(0, 1'b1);
    checkOutput("abort_busy", 32'(busyMain), 32'd0);
    checkOutput("abort_valid", 32'(curValid), 32'd0);
    checkOutput("abort_instr", dutMain.uInstrCnt.value_o, 32'd3);
    checkOutput("abort_br", dutMain.uBrCnt.value_o, 32'd2);
    checkOutput("abort_miss", dutMain.uMissCnt.value_o, 32'd0);
    pulseArm(0, 1'b1);
    applyStimulus(ADDI, 1'b1, 1'b1, 1'b1);
    checkOutput("armabort_busy", 32'(busyMain), 32'd0);
    checkOutput("armabort_instr", dutMain.uInstrCnt.value_o, 32'd3);
    checkOutput("idle_br", dutMain.uBrCnt.value_o, 32'd2);
    pulseArm(0, 1'b0);
    checkOutput("rearm_busy", 32'(busyMain), 32'd1);
    checkOutput("rearm_instr", dutMain.uInstrCnt.value_o, 32'd0);
    pulseAbort();

    $display("[TB] saturation on 4-bit instance");
    sel = 1;
    pulseArm(1, 1'b0);
    applyStimulus(START, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(ADDI, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(STOP, 1'b1, 1'b0, 1'b0);
    readWords("sat", 32'd15, 32'd0, 32'd0, 32'd1, -1, 0);
    checkOutput("sat_ovf", 32'(ovfSmall), 32'd1);
    pulseArm(1, 1'b0);
    checkOutput("sat_ovfClr", 32'(ovfSmall), 32'd0);
    pulseAbort();

    $display("[TB] instruction window instance");
    sel = 2;
    pulseArm(2, 1'b0);
    applyStimulus(START, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(ADDI, 1'b1, 1'b0, 1'b0);
    end
`ifdef PERF_WINDOW_EN
    readWords("win", 32'd8, 32'd0, 32'd0, 32'd2, -1, 0);
`else
    applyStimulus(STOP, 1'b1, 1'b0, 1'b0);
    readWords("win", 32'd12, 32'd0, 32'd0, 32'd0, -1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
